// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Single-port memory arbiter. Shares one memory interface among NUM_REQ
//   requesters (control-unit fetch/data, DMA, debug). Accesses are serialised
//   with round-robin priority. The arbiter drives the read/write strobes,
//   address and write data to memory. It returns read data plus a one-cycle
//   completion pulse to the granted requester.
//
//   Transaction shape: one IDLE cycle samples the requests, then BUSY holds
//   until mem_ready, then one RESP cycle pulses done (or err). A requester
//   that keeps req high is therefore re-granted at most every 3 cycles.
//
// Optional feature:
//   MEM_ARB_TIMEOUT_EN
//     - Defined: a wait counter aborts a BUSY phase after TIMEOUT cycles
//       without mem_ready. The abort pulses err instead of done.
//     - Undefined: BUSY waits indefinitely and err is tied to 0.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   ADDR_W   address width
//   DATA_W   data width
//   TIMEOUT  max BUSY cycles waiting for mem_ready (timeout build only)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req        in   per-requester access request (level)
//   req_wr     in   per-requester direction, 1=write 0=read
//   req_addr   in   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata  in   packed write data, same packing
//   gnt        out  one-hot grant, zero when idle
//   done       out  one-cycle completion pulse to the granted requester
//   err        out  one-cycle timeout pulse to the granted requester
//   rdata      out  data of the last completed read
//   mem_rd     out  memory read strobe
//   mem_wr     out  memory write strobe
//   mem_addr   out  memory address
//   mem_wdata  out  memory write data
//   mem_rdata  in   memory read data, valid with mem_ready
//   mem_ready  in   memory completion
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_rd,
  output logic                      mem_wr,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ready
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Round-robin pick. The result is {found, index}. The scan runs from the
  // highest offset down, so the last hit is the one closest to the pointer.
  function automatic logic [PTR_W:0] f_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [PTR_W-1:0]   p);
    logic [PTR_W:0] res;
    int             idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (r[idx]) begin
        res = {1'b1, idx[PTR_W-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // One-hot vector with the bit at idx set.
  function automatic logic [NUM_REQ-1:0] f_onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // (idx + 1) mod NUM_REQ. The wrap is explicit because NUM_REQ need not be
  // a power of two.
  function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] idx);
    logic [PTR_W-1:0] nxt;
    if (idx == PTR_W'(NUM_REQ - 1)) begin
      nxt = '0;
    end else begin
      nxt = idx + PTR_W'(1);
    end
    return nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic               r_mem_rd;
  logic               r_mem_wr;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [DATA_W-1:0]  r_rdata;

  logic [PTR_W:0]     w_pick;
  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;
  logic               w_wr;
  logic               w_timeout;

  // Arbitration decode: winner index and the winner's request fields.
  always_comb begin
    w_pick  = f_pick(req, r_ptr);
    w_found = w_pick[PTR_W];
    w_win   = w_pick[PTR_W-1:0];
    w_addr  = '0;
    w_wdata = '0;
    w_wr    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == PTR_W'(i)) begin
        w_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_wdata = req_wdata[i*DATA_W +: DATA_W];
        w_wr    = req_wr[i];
      end else begin
        w_addr  = w_addr;
        w_wdata = w_wdata;
        w_wr    = w_wr;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_err;

  // The count holds the BUSY cycles already spent without mem_ready. The
  // cycle that would make it reach TIMEOUT is the abort point. mem_ready on
  // that same edge still wins.
  assign w_timeout = (r_state == S_BUSY) && !mem_ready && (r_cnt == CNT_LAST);
  assign err       = r_err;

  // Wait counter and timeout pulse. The counter is zero whenever BUSY is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= '0;
    end else begin
      case (r_state)
        S_BUSY: begin
          if (w_timeout) begin
            r_err <= r_gnt;
            r_cnt <= '0;
          end else if (mem_ready) begin
            r_err <= '0;
            r_cnt <= '0;
          end else begin
            r_err <= '0;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_err <= '0;
          r_cnt <= '0;
        end
      endcase
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = {NUM_REQ{1'b0}};
`endif

  // Main FSM plus memory-side and requester-side output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= '0;
          if (w_found) begin
            r_state     <= S_BUSY;
            r_ptr       <= f_next_ptr(w_win);
            r_gnt       <= f_onehot(w_win);
            r_mem_rd    <= ~w_wr;
            r_mem_wr    <= w_wr;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
          end else begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
          end
        end

        // Requester inputs are deliberately ignored here.
        // A dropped req does not abort an access that is already in flight.
        S_BUSY: begin
          if (mem_ready) begin
            r_state  <= S_RESP;
            r_done   <= r_gnt;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            if (r_mem_rd) begin
              r_rdata <= mem_rdata;
            end else begin
              r_rdata <= r_rdata;
            end
          end else if (w_timeout) begin
            r_state  <= S_RESP;
            r_done   <= '0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
          end else begin
            r_state <= S_BUSY;
          end
        end

        // Single response cycle. The grant is still visible while done/err
        // pulse, then everything except rdata returns to zero.
        S_RESP: begin
          r_state     <= S_IDLE;
          r_gnt       <= '0;
          r_done      <= '0;
          r_mem_rd    <= 1'b0;
          r_mem_wr    <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
        end

        // Unreachable encoding: recover to a clean idle.
        default: begin
          r_state     <= S_IDLE;
          r_gnt       <= '0;
          r_done      <= '0;
          r_mem_rd    <= 1'b0;
          r_mem_wr    <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter.
- Shares one memory interface among NUM_REQ requesters: control-unit fetch/data, DMA, debug.
- Serialises accesses with round-robin priority and drives mem_rd/mem_wr/address/data to memory.
- Returns read data plus a one-cycle completion pulse to the granted requester.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, max BUSY cycles waiting for mem_ready (only used with MEM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  access request per requester, level.
- req_wr  in  NUM_REQ  1=write, 0=read, per requester.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing.
- gnt  out  NUM_REQ  one-hot grant; all zero when idle.
- done  out  NUM_REQ  one-cycle completion pulse to granted requester.
- err  out  NUM_REQ  one-cycle timeout pulse.
- rdata  out  DATA_W  last read data.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion.

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset (async, any state, including mid-transaction):
  - state=IDLE, rr pointer=0, wait counter=0.
  - gnt, done, err, mem_rd, mem_wr = 0.
  - mem_addr, mem_wdata, rdata = 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any req bit is set at a rising edge:
  - Winner = first set bit searching upward (wrapping) from rr pointer.
  - Next cycle: state=BUSY, gnt=onehot(winner).
  - mem_addr/mem_wdata registered from the winner's slice; mem_rd=~req_wr[w], mem_wr=req_wr[w].
  - rr pointer = (w+1) mod NUM_REQ.
  - No req: remain IDLE, all outputs held at 0 except rdata.
- BUSY:
  - Outputs held constant; requester inputs are not re-sampled (deasserting req mid-BUSY does not abort).
  - mem_ready sampled each edge. On mem_ready=1: next cycle state=RESP, done[w]=1, mem_rd=mem_wr=0.
  - For reads, rdata<=mem_rdata on that same edge. Writes leave rdata unchanged.
- RESP: lasts exactly one cycle. gnt still asserted, done pulses. Then IDLE with gnt=0.
- Minimum transaction: 3 cycles (IDLE sample, BUSY with mem_ready, RESP); back-to-back grant every 3 cycles.
- Requester keeps req high to be re-arbitrated. Round-robin prevents any requester waiting more than NUM_REQ-1 transactions.
- mem_ready outside BUSY is ignored.
- Exactly one gnt bit is set in BUSY/RESP; mem_rd and mem_wr are never both 1.
- rdata holds its value until the next completed read.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - Wait counter clears on entering BUSY and increments each BUSY cycle without mem_ready.
  - When it reaches TIMEOUT: next cycle state=RESP, err[w]=1 for one cycle, done[w]=0, strobes dropped, rdata unchanged.
  - mem_ready on the same edge as the TIMEOUT count wins: normal completion, no err.
- MEM_ARB_TIMEOUT_EN undefined:
  - BUSY waits indefinitely.
  - err tied to 0; no counter logic.

Test Plan:
- Reset/idle: rst_n=0 mid-BUSY (gnt=001, mem_rd=1) → same cycle all outputs 0; after release with req=0 → gnt stays 000.
- Single read: req=001, req_wr=0, addr0=0x10, mem_ready after 2 BUSY cycles with mem_rdata=0xDEADBEEF → mem_rd=1, mem_addr=0x10, gnt=001; done=001 one cycle; rdata=0xDEADBEEF; IDLE after.
- Write: req=010, req_wr=010, addr1=0x20, wdata1=0x12345678, immediate mem_ready → mem_wr=1, mem_wdata=0x12345678, done=010; rdata unchanged.
- Round-robin: req=111 held, mem_ready=1 always → grant order 001,010,100,001; each done pulse 3 cycles apart.
- Drop request: req=100 deasserted during BUSY → access completes, done=100, then gnt=000.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT=4): req=001, mem_ready=0 → after 4 BUSY cycles err=001 one cycle, done=000, mem_rd=0. Repeat with mem_ready on the 4th cycle → done=001, err=000.
